// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter register, next-PC selection and run-control
// FSM for the single-cycle MIPS datapath.
//
// Optional feature macro: PC_NEXT_PERF_CNT_EN
//   defined   -> retire_cnt / taken_cnt performance counters are built
//   undefined -> retire_cnt / taken_cnt are tied to zero
//
// The PC advances only in RUN with en high. BOOT spends one cycle letting the
// first fetch settle. A jump whose target is its own address ("j .") parks
// the machine in HALT until reset.
module pc_next_unit #(
  parameter int unsigned      PC_WIDTH = 32,
  parameter logic [31:0]      RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [31:0]         instruction,
  input  logic                branch,
  input  logic                jump,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                inst_valid,
  output logic                halted,
  output logic [31:0]         retire_cnt,
  output logic [31:0]         taken_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } runState_t;

  runState_t             r_state;
  runState_t             w_stateNext;

  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pcPlus4;
  logic [PC_WIDTH-1:0]   w_brOffset;
  logic [PC_WIDTH-1:0]   w_brTarget;
  logic [PC_WIDTH-1:0]   w_jumpTarget;
  logic [PC_WIDTH-1:0]   w_nextPc;
  logic                  w_isBne;
  logic                  w_brTaken;
  logic                  w_selfJump;
  logic                  w_advance;

  // Sequential-PC and branch/jump target arithmetic, all modulo 2^PC_WIDTH.
  // The branch offset is the sign-extended word displacement; the jump target
  // keeps the upper nibble of the PC+4 region and drops in the 26-bit index.
  always_comb begin
    w_pcPlus4    = r_pc + PC_WIDTH'(4);
    w_brOffset   = {{(PC_WIDTH-18){instruction[15]}}, instruction[15:0], 2'b00};
    w_brTarget   = w_pcPlus4 + w_brOffset;
    w_jumpTarget = {w_pcPlus4[PC_WIDTH-1 -: 4], instruction[25:0], 2'b00};
  end

  // Branch sense comes from opcode bit 26: BEQ wants zero set, BNE wants it
  // clear. A jump has priority over a branch if the decoder raises both.
  always_comb begin
    w_isBne   = instruction[26];
    w_brTaken = branch & (w_isBne ? ~zero : zero);
    if (jump) begin
      w_nextPc = w_jumpTarget;
    end else if (w_brTaken) begin
      w_nextPc = w_brTarget;
    end else begin
      w_nextPc = w_pcPlus4;
    end
  end

  // An instruction retires when we are running and not stalled; a self-jump
  // is the halt idiom, while a self-branch simply spins in RUN.
  always_comb begin
    w_advance  = (r_state == ST_RUN) && en;
    w_selfJump = jump && (w_jumpTarget == r_pc);
  end

  // Run-control next state: BOOT always leaves after one cycle, RUN halts on
  // a retired self-jump, HALT is sticky until reset.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_BOOT: begin
        w_stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (w_advance && w_selfJump) begin
          w_stateNext = ST_HALT;
        end
      end
      ST_HALT: begin
        w_stateNext = ST_HALT;
      end
      default: begin
        w_stateNext = ST_BOOT;
      end
    endcase
  end

  // State register; reset dominates the enable so a stalled or halted core
  // can always be restarted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // PC register: loads the selected next PC only on a retiring cycle. On the
  // halting self-jump the next PC equals the current PC, so it parks in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC[PC_WIDTH-1:0];
    end else if (w_advance) begin
      r_pc <= w_nextPc;
    end
  end

`ifdef PC_NEXT_PERF_CNT_EN
  logic [31:0] r_retireCnt;
  logic [31:0] r_takenCnt;

  // Performance counters: every retiring cycle counts, and those that
  // redirect the PC (jump or taken branch) also count as taken. Both wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retireCnt <= 32'h0;
      r_takenCnt  <= 32'h0;
    end else if (w_advance) begin
      r_retireCnt <= r_retireCnt + 32'd1;
      if (jump || w_brTaken) begin
        r_takenCnt <= r_takenCnt + 32'd1;
      end
    end
  end

  assign retire_cnt = r_retireCnt;
  assign taken_cnt  = r_takenCnt;
`else
  assign retire_cnt = 32'h0;
  assign taken_cnt  = 32'h0;
`endif

  assign pc         = r_pc;
  assign pc_plus4   = w_pcPlus4;
  assign inst_valid = (r_state == ST_RUN);
  assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed self-checking bench for pc_next_unit.
// Expected values are hand-computed. Counter expectations follow the
// PC_NEXT_PERF_CNT_EN macro so the bench works in both builds.
module tb_pc_next_unit;

`ifdef PC_NEXT_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] instruction;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        instValid;
  logic        halted;
  logic [31:0] retireCnt;
  logic [31:0] takenCnt;

  logic [31:0] pcWrap;
  logic [31:0] pcPlus4Wrap;
  logic        instValidWrap;
  logic        haltedWrap;
  logic [31:0] retireCntWrap;
  logic [31:0] takenCntWrap;

  int checks;
  int failures;

  pc_next_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .instruction(instruction),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .pc         (pc),
    .pc_plus4   (pcPlus4),
    .inst_valid (instValid),
    .halted     (halted),
    .retire_cnt (retireCnt),
    .taken_cnt  (takenCnt)
  );

  // Second instance booting at the top of the address space to exercise wrap.
  pc_next_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .instruction(instruction),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .pc         (pcWrap),
    .pc_plus4   (pcPlus4Wrap),
    .inst_valid (instValidWrap),
    .halted     (haltedWrap),
    .retire_cnt (retireCntWrap),
    .taken_cnt  (takenCntWrap)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the decode-side inputs, then take one clock and settle 1 unit past it.
  task automatic applyStimulus(input logic [31:0] instr, input logic br,
                               input logic jmp, input logic z, input logic e);
    instruction = instr;
    branch      = br;
    jump        = jmp;
    zero        = z;
    en          = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    en          = 1'b1;
    instruction = 32'h0;
    branch      = 1'b0;
    jump        = 1'b0;
    zero        = 1'b0;

    // Reset edge, then BOOT.
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    checkOutput("boot_pc", pc, 32'h0);
    checkOutput("boot_valid", {31'd0, instValid}, 32'd0);
    checkOutput("boot_halted", {31'd0, halted}, 32'd0);
    checkOutput("boot_retire", retireCnt, 32'd0);
    checkOutput("boot_taken", takenCnt, 32'd0);
    checkOutput("wrap_boot_pc", pcWrap, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", pcPlus4Wrap, 32'h0);

    // BOOT -> RUN, pc holds.
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("run_valid", {31'd0, instValid}, 32'd1);
    checkOutput("run_pc0", pc, 32'h0);

    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("seq_pc4", pc, 32'h4);
    checkOutput("wrap_pc0", pcWrap, 32'h0);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("seq_pc8", pc, 32'h8);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("seq_pcC", pc, 32'hC);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("seq_pc10", pc, 32'h10);
    checkOutput("plus4_at10", pcPlus4, 32'h14);

    // BEQ taken / not taken from 0x10, jumping back to 0x10 in between.
    applyStimulus(32'h1000_0003, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("beq_taken", pc, 32'h20);
    applyStimulus(32'h0800_0004, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("jump_to10_a", pc, 32'h10);
    applyStimulus(32'h1000_0003, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("beq_not_taken", pc, 32'h14);
    applyStimulus(32'h0800_0004, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("jump_to10_b", pc, 32'h10);

    // BNE backward taken / not taken.
    applyStimulus(32'h1400_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bne_taken", pc, 32'hC);
    applyStimulus(32'h0800_0004, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("jump_to10_c", pc, 32'h10);
    applyStimulus(32'h1400_FFFE, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("bne_not_taken", pc, 32'h14);

    // Self-branch spins in RUN without halting.
    applyStimulus(32'h1000_FFFF, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("self_branch_pc", pc, 32'h14);
    checkOutput("self_branch_halted", {31'd0, halted}, 32'd0);
    checkOutput("self_branch_valid", {31'd0, instValid}, 32'd1);

    // Jump and taken branch together: jump wins (0x40, not 0x58).
    applyStimulus(32'h0800_0010, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("jump_priority", pc, 32'h40);

    // Non-self jump keeps running; self-jump halts.
    applyStimulus(32'h0800_0020, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("jump_to80", pc, 32'h80);
    checkOutput("jump_to80_halted", {31'd0, halted}, 32'd0);
    applyStimulus(32'h0800_0020, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("halt_pc", pc, 32'h80);
    checkOutput("halt_flag", {31'd0, halted}, 32'd1);
    checkOutput("halt_valid", {31'd0, instValid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, i[0]);
      checkOutput("halt_hold_pc", pc, 32'h80);
      checkOutput("halt_hold_flag", {31'd0, halted}, 32'd1);
    end

    // Reset out of HALT.
    reset = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    checkOutput("rst_halt_pc", pc, 32'h0);
    checkOutput("rst_halt_flag", {31'd0, halted}, 32'd0);
    checkOutput("rst_halt_valid", {31'd0, instValid}, 32'd0);
    checkOutput("rst_halt_retire", retireCnt, 32'd0);

    // RUN then five NOPs to 0x14.
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("pre_stall_pc", pc, 32'h14);
    checkOutput("pre_stall_retire", retireCnt, PERF ? 32'd5 : 32'd0);

    // Stall for five clocks with a branch presented: nothing moves.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h1000_0003, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("stall_pc", pc, 32'h14);
      checkOutput("stall_valid", {31'd0, instValid}, 32'd1);
    end
    checkOutput("stall_retire", retireCnt, PERF ? 32'd5 : 32'd0);
    checkOutput("stall_taken", takenCnt, 32'd0);

    // Advance to 0x2C, then reset with en low.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("pre_rst_pc", pc, 32'h2C);
    reset = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rst_mid_pc", pc, 32'h0);
    checkOutput("rst_mid_valid", {31'd0, instValid}, 32'd0);

    // Six retired instructions, two taken, one stall cycle in the middle.
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("cnt_run_pc", pc, 32'h0);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h1000_0001, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("cnt_beq_pc", pc, 32'hC);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt_stall_pc", pc, 32'hC);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h1400_0001, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("cnt_bne_pc", pc, 32'h18);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h1000_0001, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("cnt_final_pc", pc, 32'h20);
    checkOutput("cnt_retire", retireCnt, PERF ? 32'd6 : 32'd0);
    checkOutput("cnt_taken", takenCnt, PERF ? 32'd2 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
